ts_rcv: RTL and testbench
=========================

Name: ts_rcv

Overview:
- Receive-side counterpart of the training-sequence generator: pops 128-bit TS1/TS2 ordered sets from the RX TS FIFO and checks that their framing is valid.
- Counts consecutive identical TS of the type the LTSSM expects, and raises `rcv_enough` once the count reaches the threshold.
- Exposes the decoded fields of the last valid TS to the LTSSM.

Parameters:
- RCV_THRESH, 8: consecutive identical expected-type TS needed to assert `rcv_enough`.
- CNT_W, 5: width of the consecutive counter; must hold RCV_THRESH.

Ports:
- clk  input  1  1GHz system clock.
- rst  input  1  asynchronous, active-low reset.
- speed  input  1  0 = 8b/10b framing (Gen1/2), 1 = 128b/130b framing (Gen3); sampled per TS.
- exp_ts2  input  1  expected type: 0 = TS1, 1 = TS2.
- ts_clr  input  1  pulse on LTSSM state change; restarts counting.
- ts  input  128  incoming TS; byte k = ts[8k+7:8k].
- ts_valid  input  1  FIFO has a TS.
- ts_ready  output  1  pop strobe to FIFO.
- rcv_enough  output  1  threshold reached (level).
- rcv_cnt  output  CNT_W  current consecutive count.
- ts_err  output  1  one-cycle pulse: malformed TS popped.
- rcvd_ts2  output  1  type of the last valid TS.
- rcvd_link  output  8  byte1 of the last valid TS.
- rcvd_lane  output  8  byte2 of the last valid TS.
- rcvd_nfts  output  8  byte3 of the last valid TS.
- rcvd_rate  output  8  byte4 of the last valid TS.
- rcvd_ctrl  output  8  byte5 of the last valid TS.

Behaviour:
- **Reset.** All outputs 0, `rcv_cnt` = 0, previous-TS register cleared, `prev_vld` = 0. Reset is asynchronous, active-low, and may occur mid-sequence: all state is lost and counting restarts.
- **Pop.** `ts_ready` = 1 whenever out of reset. A transfer occurs on `ts_valid & ts_ready`, giving at most one TS per cycle.
- **Framing check, speed = 0.**
  - byte0 must be 8'hBC (COM).
  - bytes6..15 must all be 8'h4A (TS1) or all 8'h45 (TS2).
- **Framing check, speed = 1.**
  - byte0 must be 8'h1E (TS1) or 8'h2D (TS2).
  - bytes6..15 must all be 8'h4A (TS1) or all 8'h45 (TS2).
  - The type given by byte0 must agree with the type given by the identifier bytes.
  - Any violation makes the TS malformed.
- **Registered output.** Pipeline is 2 stages: stage1 registers the popped TS plus check results; stage2 updates the counter and outputs. Every output changes exactly 2 cycles after the pop edge.
- **Malformed TS.**
  - `ts_err` = 1 for one cycle.
  - `rcv_cnt` <= 0, `prev_vld` <= 0.
  - `rcvd_*` fields hold their previous values.
- **Valid TS of the wrong type** (type != `exp_ts2`):
  - `rcvd_*` fields are updated.
  - `rcv_cnt` <= 0, `prev_vld` <= 0.
  - No `ts_err`.
- **Valid TS of the expected type:**
  - `rcvd_*` fields are updated.
  - If `prev_vld` and bytes1..15 equal the previous TS: `rcv_cnt` <= `rcv_cnt` + 1, saturating at 2^CNT_W - 1.
  - Otherwise: `rcv_cnt` <= 1.
  - Store bytes1..15 as the previous TS; `prev_vld` <= 1.
- **Threshold.** `rcv_enough` is registered, = (`rcv_cnt` >= RCV_THRESH). It stays high across further identical TS and drops with the counter.
- **ts_clr.**
  - `ts_clr` is aligned to the stage2 update.
  - On its own: `rcv_cnt` <= 0, `prev_vld` <= 0, `rcv_enough` <= 0.
  - When coincident with an expected-type valid TS in stage2: that TS counts as the first one (`rcv_cnt` <= 1), and `rcv_enough` <= 0.
  - `rcvd_*` fields are not cleared.
- **exp_ts2 change.** A change of `exp_ts2` without `ts_clr` takes effect on the next stage2 TS and does not clear the count by itself.
- **Idle.** No pop means no change; gaps between TS do not break a consecutive run.

Test Plan:
- Gen1, `exp_ts2` = 0, 8 identical TS1 (link 8'h00, lane 8'h03) back-to-back -> `rcv_cnt` steps 1..8; `rcv_enough` = 1 two cycles after the 8th pop; `rcvd_lane` = 8'h03.
- 5 identical TS1, then one with byte3 changed, then 7 more of the new value -> `rcv_cnt` drops to 1 and reaches 8; `rcv_enough` is asserted only after the 7th post-change TS.
- Mid-run TS with byte0 = 8'hBD -> `ts_err` single pulse; `rcv_cnt` = 0; `rcvd_*` unchanged.
- `exp_ts2` = 1, stream of 10 TS1 -> `rcv_cnt` stays 0; `rcvd_ts2` = 0; no `ts_err`. Then 8 TS2 -> `rcv_enough` = 1.
- speed = 1: byte0 = 8'h2D with identifier bytes 8'h4A -> `ts_err`. byte0 = 8'h1E with identifier bytes 8'h4A, x8 -> `rcv_enough`.
- `ts_clr` coincident with the 9th TS of a saturated run -> `rcv_cnt` = 1, `rcv_enough` = 0. Separately, rst low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/ts_rcv.sv
// Training-sequence receiver: pops TS1/TS2 ordered sets, checks framing, counts
// consecutive identical expected-type TS and reports the fields of the last valid one.
module ts_rcv #(
    parameter int RCV_THRESH = 8,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             speed,
    input  logic             exp_ts2,
    input  logic             ts_clr,
    input  logic [127:0]     ts,
    input  logic             ts_valid,
    output logic             ts_ready,
    output logic             rcv_enough,
    output logic [CNT_W-1:0] rcv_cnt,
    output logic             ts_err,
    output logic             rcvd_ts2,
    output logic [7:0]       rcvd_link,
    output logic [7:0]       rcvd_lane,
    output logic [7:0]       rcvd_nfts,
    output logic [7:0]       rcvd_rate,
    output logic [7:0]       rcvd_ctrl
);

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] STP_TS1 = 8'h1E;
    localparam logic [7:0] STP_TS2 = 8'h2D;
    localparam logic [7:0] ID_TS1  = 8'h4A;
    localparam logic [7:0] ID_TS2  = 8'h45;

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(RCV_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ---------------------------------------------------------------- stage 1
    logic         w_pop;
    logic         w_id_ts1;
    logic         w_id_ts2;
    logic         w_ok;
    logic         w_is_ts2;

    logic         r_s1_vld;
    logic         r_s1_ok;
    logic         r_s1_ts2;
    logic [119:0] r_s1_body;

    // The receiver never back-pressures; it is ready whenever out of reset.
    assign ts_ready = rst;
    assign w_pop    = ts_valid & ts_ready;

    assign w_id_ts1 = (ts[127:48] == {10{ID_TS1}});
    assign w_id_ts2 = (ts[127:48] == {10{ID_TS2}});

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_ok     = 1'b0;
        w_is_ts2 = w_id_ts2;
        if (speed) begin
            // Gen3: the sync-header symbol names the type and must agree with the identifiers.
            w_is_ts2 = (ts[7:0] == STP_TS2);
            w_ok     = ((ts[7:0] == STP_TS1) && w_id_ts1) ||
                       ((ts[7:0] == STP_TS2) && w_id_ts2);
        end else begin
            w_ok     = (ts[7:0] == SYM_COM) && (w_id_ts1 || w_id_ts2);
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_ok   <= 1'b0;
            r_s1_ts2  <= 1'b0;
            r_s1_body <= '0;
        end else begin
            r_s1_vld <= w_pop;
            if (w_pop) begin
                r_s1_ok   <= w_ok;
                r_s1_ts2  <= w_is_ts2;
                r_s1_body <= ts[127:8];
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic             r_prev_vld;
    logic [119:0]     r_prev_body;
    logic [CNT_W-1:0] r_cnt;
    logic             r_enough;
    logic             r_err;
    logic             r_ts2;
    logic [39:0]      r_fields;

    logic             w_prev_vld;
    logic [119:0]     w_prev_body;
    logic [CNT_W-1:0] w_cnt;
    logic             w_enough;
    logic             w_err;
    logic             w_ts2;
    logic [39:0]      w_fields;
    logic             w_same;

    assign w_same = r_prev_vld && (r_s1_body == r_prev_body);

    always_comb begin
        w_prev_vld  = r_prev_vld;
        w_prev_body = r_prev_body;
        w_cnt       = r_cnt;
        w_err       = 1'b0;
        w_ts2       = r_ts2;
        w_fields    = r_fields;

        if (ts_clr) begin
            w_cnt      = '0;
            w_prev_vld = 1'b0;
        end

        if (r_s1_vld) begin
            if (!r_s1_ok) begin
                w_err      = 1'b1;
                w_cnt      = '0;
                w_prev_vld = 1'b0;
            end else begin
                w_ts2    = r_s1_ts2;
                w_fields = r_s1_body[39:0];
                if (r_s1_ts2 != exp_ts2) begin
                    w_cnt      = '0;
                    w_prev_vld = 1'b0;
                end else begin
                    // A coincident clear makes this TS the first of a new run.
                    if (w_same && !ts_clr)
                        w_cnt = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_ONE;
                    else
                        w_cnt = CNT_ONE;
                    w_prev_body = r_s1_body;
                    w_prev_vld  = 1'b1;
                end
            end
        end

        w_enough = !ts_clr && (w_cnt >= THRESH_C);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_vld  <= 1'b0;
            r_prev_body <= '0;
            r_cnt       <= '0;
            r_enough    <= 1'b0;
            r_err       <= 1'b0;
            r_ts2       <= 1'b0;
            r_fields    <= '0;
        end else begin
            r_prev_vld  <= w_prev_vld;
            r_prev_body <= w_prev_body;
            r_cnt       <= w_cnt;
            r_enough    <= w_enough;
            r_err       <= w_err;
            r_ts2       <= w_ts2;
            r_fields    <= w_fields;
        end
    end

    assign rcv_cnt    = r_cnt;
    assign rcv_enough = r_enough;
    assign ts_err     = r_err;
    assign rcvd_ts2   = r_ts2;
    assign rcvd_link  = r_fields[7:0];
    assign rcvd_lane  = r_fields[15:8];
    assign rcvd_nfts  = r_fields[23:16];
    assign rcvd_rate  = r_fields[31:24];
    assign rcvd_ctrl  = r_fields[39:32];

endmodule

// File: tb/tb_ts_rcv.sv
// Directed bench for ts_rcv: framing checks, consecutive counting, threshold,
// ts_clr interaction, saturation and asynchronous reset.
`timescale 1ns/1ps
module tb_ts_rcv;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         speed = 1'b0;
    logic         exp_ts2 = 1'b0;
    logic         ts_clr = 1'b0;
    logic [127:0] ts = '0;
    logic         ts_valid = 1'b0;
    logic         ts_ready;
    logic         rcv_enough;
    logic [4:0]   rcv_cnt;
    logic         ts_err;
    logic         rcvd_ts2;
    logic [7:0]   rcvd_link;
    logic [7:0]   rcvd_lane;
    logic [7:0]   rcvd_nfts;
    logic [7:0]   rcvd_rate;
    logic [7:0]   rcvd_ctrl;

    int n_asserts = 0;
    int n_fail    = 0;

    ts_rcv #(.RCV_THRESH(8), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .speed      (speed),
        .exp_ts2    (exp_ts2),
        .ts_clr     (ts_clr),
        .ts         (ts),
        .ts_valid   (ts_valid),
        .ts_ready   (ts_ready),
        .rcv_enough (rcv_enough),
        .rcv_cnt    (rcv_cnt),
        .ts_err     (ts_err),
        .rcvd_ts2   (rcvd_ts2),
        .rcvd_link  (rcvd_link),
        .rcvd_lane  (rcvd_lane),
        .rcvd_nfts  (rcvd_nfts),
        .rcvd_rate  (rcvd_rate),
        .rcvd_ctrl  (rcvd_ctrl)
    );

    always #0.5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_ts(input logic gen3, input logic is_ts2,
                                           input logic [7:0] link, input logic [7:0] lane,
                                           input logic [7:0] nfts, input logic [7:0] rate,
                                           input logic [7:0] ctrl);
        logic [7:0] b0;
        logic [7:0] id;
        b0 = gen3 ? (is_ts2 ? 8'h2D : 8'h1E) : 8'hBC;
        id = is_ts2 ? 8'h45 : 8'h4A;
        return {{10{id}}, ctrl, rate, nfts, lane, link, b0};
    endfunction

    // Called at a falling edge; returns at the falling edge where this TS's results are visible.
    task automatic send(input logic [127:0] d, input logic clr);
        ts       = d;
        ts_valid = 1'b1;
        @(negedge clk);
        ts_valid = 1'b0;
        ts_clr   = clr;
        @(negedge clk);
        ts_clr   = 1'b0;
    endtask

    logic [127:0] a_ts, b_ts, c_ts, d_ts, bad;

    initial begin
        a_ts = mk_ts(1'b0, 1'b0, 8'h00, 8'h03, 8'h1F, 8'h02, 8'h00);
        b_ts = mk_ts(1'b0, 1'b0, 8'h00, 8'h03, 8'h20, 8'h02, 8'h00);
        c_ts = mk_ts(1'b0, 1'b1, 8'h00, 8'h03, 8'h1F, 8'h02, 8'h00);
        d_ts = mk_ts(1'b1, 1'b0, 8'h01, 8'h02, 8'h30, 8'h04, 8'h08);

        // Reset state
        #2.2;
        check("rst_ready",  ts_ready,   0);
        check("rst_cnt",    rcv_cnt,    0);
        check("rst_enough", rcv_enough, 0);
        check("rst_err",    ts_err,     0);
        check("rst_lane",   rcvd_lane,  0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ready_up", ts_ready, 1);

        // Gen1 back-to-back run of 8 identical TS1
        for (int i = 0; i < 10; i++) begin
            if (i >= 2) check("b2b_cnt", rcv_cnt, i - 1);
            if (i == 8) check("b2b_enough_lo", rcv_enough, 0);
            if (i == 9) check("b2b_enough_hi", rcv_enough, 1);
            ts       = a_ts;
            ts_valid = (i < 8);
            @(negedge clk);
        end
        check("b2b_lane", rcvd_lane, 8'h03);
        check("b2b_ts2",  rcvd_ts2,  0);
        check("b2b_ctrl", rcvd_ctrl, 8'h00);

        // ts_clr alone
        ts_clr = 1'b1;
        @(negedge clk);
        ts_clr = 1'b0;
        check("clr_cnt",    rcv_cnt,    0);
        check("clr_enough", rcv_enough, 0);
        check("clr_lane",   rcvd_lane,  8'h03);

        // 5 identical, then byte3 changes, then 7 more of the new value (with gaps)
        for (int i = 0; i < 5; i++) send(a_ts, 1'b0);
        check("run5_cnt", rcv_cnt, 5);
        send(b_ts, 1'b0);
        check("chg_cnt",  rcv_cnt,   1);
        check("chg_nfts", rcvd_nfts, 8'h20);
        for (int j = 1; j <= 7; j++) begin
            send(b_ts, 1'b0);
            check("post_cnt", rcv_cnt, j + 1);
            check("post_enough", rcv_enough, (j == 7) ? 1 : 0);
        end
        send(b_ts, 1'b0);
        check("post9_cnt", rcv_cnt, 9);

        // Malformed COM mid-run
        bad = mk_ts(1'b0, 1'b0, 8'h00, 8'h07, 8'h55, 8'h02, 8'h00);
        bad[7:0] = 8'hBD;
        send(bad, 1'b0);
        check("bad_err",    ts_err,     1);
        check("bad_cnt",    rcv_cnt,    0);
        check("bad_enough", rcv_enough, 0);
        check("bad_lane",   rcvd_lane,  8'h03);
        check("bad_nfts",   rcvd_nfts,  8'h20);
        @(negedge clk);
        check("bad_err_pulse", ts_err, 0);
        send(b_ts, 1'b0);
        check("after_bad_cnt", rcv_cnt, 1);

        // exp_ts2 change does not clear count by itself
        exp_ts2 = 1'b1;
        repeat (3) @(negedge clk);
        check("exp_chg_hold", rcv_cnt, 1);

        // Expecting TS2 but receiving TS1
        for (int i = 0; i < 10; i++) begin
            send(a_ts, 1'b0);
            check("wrong_cnt", rcv_cnt, 0);
            check("wrong_err", ts_err,  0);
        end
        check("wrong_ts2",  rcvd_ts2,  0);
        check("wrong_nfts", rcvd_nfts, 8'h1F);
        for (int i = 0; i < 8; i++) send(c_ts, 1'b0);
        check("ts2_cnt",    rcv_cnt,    8);
        check("ts2_enough", rcv_enough, 1);
        check("ts2_type",   rcvd_ts2,   1);

        // Gen3: sync symbol TS2 with TS1 identifiers is malformed
        speed   = 1'b1;
        exp_ts2 = 1'b0;
        bad = mk_ts(1'b1, 1'b1, 8'h01, 8'h02, 8'h30, 8'h04, 8'h08);
        bad[127:48] = {10{8'h4A}};
        send(bad, 1'b0);
        check("g3_bad_err",  ts_err,   1);
        check("g3_bad_cnt",  rcv_cnt,  0);
        check("g3_bad_type", rcvd_ts2, 1);
        for (int i = 0; i < 7; i++) send(d_ts, 1'b0);
        check("g3_cnt7",    rcv_cnt,    7);
        check("g3_enough7", rcv_enough, 0);
        send(d_ts, 1'b0);
        check("g3_enough8", rcv_enough, 1);
        check("g3_link",    rcvd_link,  8'h01);
        check("g3_rate",    rcvd_rate,  8'h04);
        check("g3_ctrl",    rcvd_ctrl,  8'h08);
        check("g3_ts2",     rcvd_ts2,   0);

        // ts_clr coincident with the 9th TS
        send(d_ts, 1'b1);
        check("clr9_cnt",    rcv_cnt,    1);
        check("clr9_enough", rcv_enough, 0);
        check("clr9_link",   rcvd_link,  8'h01);

        // Saturation at 31
        for (int i = 0; i < 31; i++) send(d_ts, 1'b0);
        check("sat_cnt",    rcv_cnt,    31);
        check("sat_enough", rcv_enough, 1);

        // Asynchronous reset mid-run
        send(d_ts, 1'b0);
        ts       = d_ts;
        ts_valid = 1'b1;
        #0.2;
        rst = 1'b0;
        #0.1;
        check("arst_cnt",    rcv_cnt,    0);
        check("arst_enough", rcv_enough, 0);
        check("arst_link",   rcvd_link,  0);
        check("arst_nfts",   rcvd_nfts,  0);
        check("arst_ready",  ts_ready,   0);
        ts_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(d_ts, 1'b0);
        check("post_rst_cnt",  rcv_cnt,   1);
        check("post_rst_link", rcvd_link, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
